// File: rtl/lock_arbiter_multi.sv
// Lock manager: grants and releases NUM_LOCKS locks for accelerators over a command/response stream.
// A LOCK always produces one response; an UNLOCK never does. Illegal commands raise a one-cycle err.
module lock_arbiter_multi #(
  parameter int NUM_LOCKS   = 16,
  parameter int ACC_BITS    = 4,
  parameter bit CHECK_OWNER = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [63:0]          in_data,
  input  logic [ACC_BITS-1:0]  in_id,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [63:0]          out_data,
  output logic [ACC_BITS-1:0]  out_dest,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [NUM_LOCKS-1:0] lock_status,
  output logic                 err
);

  localparam logic [7:0] CMD_LOCK   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK = 8'h06;
  localparam logic [7:0] ACK_OK     = 8'h01;
  localparam logic [7:0] ACK_REJECT = 8'h00;
  localparam int         IDX_W      = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t               state;
  state_t               state_next;
  logic [NUM_LOCKS-1:0] held;
  logic [ACC_BITS-1:0]  owner [NUM_LOCKS];

  logic [7:0]       cmd;
  logic [7:0]       lock_id;
  logic [IDX_W-1:0] idx;
  logic             id_ok;
  logic             sel_held;
  logic             owner_match;
  logic             accept;
  logic             set_lock;
  logic             clr_lock;
  logic             start_resp;
  logic             err_next;
  logic [7:0]       ack_code;

  assign cmd     = in_data[7:0];
  assign lock_id = in_data[15:8];
  assign idx     = lock_id[IDX_W-1:0];
  // The full 8-bit id is range-checked so high ids never alias onto low locks.
  assign id_ok       = ({1'b0, lock_id} < 9'(NUM_LOCKS));
  assign sel_held    = id_ok && held[idx];
  assign owner_match = (owner[idx] == in_id);

  assign in_ready    = (state == IDLE) && rstn;
  assign out_valid   = (state == RESP);
  assign accept      = in_valid && in_ready;
  assign lock_status = held;

  always_comb begin
    state_next = state;
    set_lock   = 1'b0;
    clr_lock   = 1'b0;
    start_resp = 1'b0;
    err_next   = 1'b0;
    ack_code   = ACK_REJECT;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_LOCK: begin
              start_resp = 1'b1;
              state_next = RESP;
              if (!id_ok) begin
                err_next = 1'b1;
              end else if (!sel_held) begin
                set_lock = 1'b1;
                ack_code = ACK_OK;
              end
            end
            CMD_UNLOCK: begin
              if (sel_held && (!CHECK_OWNER || owner_match)) clr_lock = 1'b1;
              else                                           err_next = 1'b1;
            end
            default: err_next = 1'b1;
          endcase
        end
      end
      RESP: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      err      <= 1'b0;
      out_data <= '0;
      out_dest <= '0;
    end else begin
      state <= state_next;
      err   <= err_next;
      if (start_resp) begin
        out_data <= {48'd0, lock_id, ack_code};
        out_dest <= in_id;
      end
    end
  end

  // Flush overrides any update decided in the same cycle; the response path is untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held <= '0;
      for (int i = 0; i < NUM_LOCKS; i++) owner[i] <= '0;
    end else if (flush) begin
      held <= '0;
      for (int i = 0; i < NUM_LOCKS; i++) owner[i] <= '0;
    end else if (set_lock) begin
      held[idx]  <= 1'b1;
      owner[idx] <= in_id;
    end else if (clr_lock) begin
      held[idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lock_arbiter_multi.sv
// Bench for lock_arbiter_multi: instance 0 checks ownership, instance 1 does not; both share stimulus
// and are compared against a table-based reference model.
module tb_lock_arbiter_multi;

  localparam int NL = 16;

  logic        clk;
  logic        rstn;
  logic [63:0] in_data;
  logic [3:0]  in_id;
  logic        in_valid;
  logic        out_ready;
  logic        flush;

  logic        o_ready  [2];
  logic [63:0] o_data   [2];
  logic [3:0]  o_dest   [2];
  logic        o_valid  [2];
  logic [15:0] o_status [2];
  logic        o_err    [2];

  int n_chk;
  int n_fail;

  // reference model state
  bit          m_held  [2][NL];
  int          m_owner [2][NL];
  bit          m_pend;
  logic [63:0] m_rdata [2];
  logic [3:0]  m_rdest;
  bit          m_err   [2];

  lock_arbiter_multi #(.NUM_LOCKS(NL), .ACC_BITS(4), .CHECK_OWNER(1'b1)) u0 (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_id(in_id), .in_valid(in_valid),
    .in_ready(o_ready[0]), .out_data(o_data[0]), .out_dest(o_dest[0]), .out_valid(o_valid[0]),
    .out_ready(out_ready), .flush(flush), .lock_status(o_status[0]), .err(o_err[0])
  );

  lock_arbiter_multi #(.NUM_LOCKS(NL), .ACC_BITS(4), .CHECK_OWNER(1'b0)) u1 (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_id(in_id), .in_valid(in_valid),
    .in_ready(o_ready[1]), .out_data(o_data[1]), .out_dest(o_dest[1]), .out_valid(o_valid[1]),
    .out_ready(out_ready), .flush(flush), .lock_status(o_status[1]), .err(o_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [7:0] c, input logic [7:0] l);
    return {48'd0, l, c};
  endfunction

  function automatic logic [15:0] exp_status(input int k);
    logic [15:0] s;
    for (int i = 0; i < NL; i++) s[i] = m_held[k][i];
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NL; i++) begin
        m_held[k][i]  = 1'b0;
        m_owner[k][i] = 0;
      end
      m_rdata[k] = '0;
      m_err[k]   = 1'b0;
    end
    m_pend  = 1'b0;
    m_rdest = '0;
  endtask

  // One clock edge of the reference behaviour, evaluated on the values presented before the edge.
  task automatic model_step(input bit v, input logic [63:0] d, input logic [3:0] id, input bit ordy, input bit fl);
    bit acc;
    int cmd;
    int lid;
    bit ok;
    bit set;
    bit clr;
    acc = v && !m_pend;
    if (m_pend && ordy) m_pend = 1'b0;
    cmd = int'(d[7:0]);
    lid = int'(d[15:8]);
    ok  = lid < NL;
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      set = 1'b0;
      clr = 1'b0;
      if (acc) begin
        if (cmd == 4) begin
          m_rdata[k] = {48'd0, d[15:8], (ok && !m_held[k][lid]) ? 8'h01 : 8'h00};
          if (!ok) m_err[k] = 1'b1;
          else if (!m_held[k][lid]) set = 1'b1;
        end else if (cmd == 6) begin
          if (ok && m_held[k][lid] && (k == 1 || m_owner[k][lid] == int'(id))) clr = 1'b1;
          else m_err[k] = 1'b1;
        end else begin
          m_err[k] = 1'b1;
        end
      end
      if (fl) begin
        for (int i = 0; i < NL; i++) begin
          m_held[k][i]  = 1'b0;
          m_owner[k][i] = 0;
        end
      end else if (set) begin
        m_held[k][lid]  = 1'b1;
        m_owner[k][lid] = int'(id);
      end else if (clr) begin
        m_held[k][lid] = 1'b0;
      end
    end
    if (acc && cmd == 4) begin
      m_pend  = 1'b1;
      m_rdest = id;
    end
  endtask

  task automatic drive_cycle(input bit v, input logic [63:0] d, input logic [3:0] id, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    in_id     = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_step(v, d, id, ordy, fl);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_id = '0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    #2;
    n_chk++; if (o_ready[0] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=0", o_ready[0]); end
    n_chk++; if (o_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", o_valid[0]); end
    n_chk++; if (o_data[0] !== 64'd0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", o_data[0]); end
    n_chk++; if (o_dest[0] !== 4'd0) begin n_fail++; $display("FAIL reset_out_dest got=%0d exp=0", o_dest[0]); end
    n_chk++; if (o_err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", o_err[0]); end
    n_chk++; if (o_status[0] !== 16'd0 || o_status[1] !== 16'd0) begin n_fail++; $display("FAIL reset_status got=%h/%h exp=0", o_status[0], o_status[1]); end
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    n_chk++; if (o_ready[0] !== 1'b1 || o_ready[1] !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%0b/%0b exp=1", o_ready[0], o_ready[1]); end
  endtask

  task automatic test_lock_ok();
    drive_cycle(1'b1, mk(8'h04, 8'h05), 4'd3, 1'b0, 1'b0);
    n_chk++; if (o_valid[0] !== 1'b1) begin n_fail++; $display("FAIL lock_out_valid got=%0b exp=1", o_valid[0]); end
    n_chk++; if (o_data[0] !== 64'h0501) begin n_fail++; $display("FAIL lock_out_data got=%h exp=0501", o_data[0]); end
    n_chk++; if (o_dest[0] !== 4'd3) begin n_fail++; $display("FAIL lock_out_dest got=%0d exp=3", o_dest[0]); end
    n_chk++; if (o_status[0][5] !== 1'b1) begin n_fail++; $display("FAIL lock_status5 got=%0b exp=1", o_status[0][5]); end
    n_chk++; if (o_ready[0] !== 1'b0) begin n_fail++; $display("FAIL lock_in_ready got=%0b exp=0", o_ready[0]); end
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    n_chk++; if (o_valid[0] !== 1'b0 || o_ready[0] !== 1'b1) begin n_fail++; $display("FAIL lock_handshake valid=%0b ready=%0b exp=0/1", o_valid[0], o_ready[0]); end
  endtask

  task automatic test_reject_and_unlock();
    drive_cycle(1'b1, mk(8'h04, 8'h05), 4'd7, 1'b1, 1'b0);
    n_chk++; if (o_data[0] !== 64'h0500 || o_data[1] !== 64'h0500) begin n_fail++; $display("FAIL reject_data got=%h/%h exp=0500", o_data[0], o_data[1]); end
    n_chk++; if (o_dest[0] !== 4'd7) begin n_fail++; $display("FAIL reject_dest got=%0d exp=7", o_dest[0]); end
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    drive_cycle(1'b1, mk(8'h06, 8'h05), 4'd7, 1'b1, 1'b0);
    n_chk++; if (o_err[0] !== 1'b1 || o_status[0][5] !== 1'b1) begin n_fail++; $display("FAIL unlock_wrong_owner_chk err=%0b held=%0b exp=1/1", o_err[0], o_status[0][5]); end
    n_chk++; if (o_err[1] !== 1'b0 || o_status[1][5] !== 1'b0) begin n_fail++; $display("FAIL unlock_wrong_owner_nochk err=%0b held=%0b exp=0/0", o_err[1], o_status[1][5]); end
    n_chk++; if (o_valid[0] !== 1'b0) begin n_fail++; $display("FAIL unlock_no_resp got=%0b exp=0", o_valid[0]); end
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    n_chk++; if (o_err[0] !== 1'b0) begin n_fail++; $display("FAIL unlock_err_pulse got=%0b exp=0", o_err[0]); end
    drive_cycle(1'b1, mk(8'h06, 8'h05), 4'd3, 1'b1, 1'b0);
    n_chk++; if (o_err[0] !== 1'b0 || o_status[0][5] !== 1'b0) begin n_fail++; $display("FAIL unlock_owner err=%0b held=%0b exp=0/0", o_err[0], o_status[0][5]); end
    n_chk++; if (o_err[1] !== 1'b1) begin n_fail++; $display("FAIL unlock_free_lock got=%0b exp=1", o_err[1]); end
  endtask

  task automatic test_illegal();
    drive_cycle(1'b1, mk(8'h04, 8'h10), 4'd2, 1'b0, 1'b0);
    n_chk++; if (o_valid[0] !== 1'b1 || o_data[0] !== 64'h1000) begin n_fail++; $display("FAIL lock_bad_id valid=%0b data=%h exp=1/1000", o_valid[0], o_data[0]); end
    n_chk++; if (o_err[0] !== 1'b1 || o_status[0] !== 16'd0) begin n_fail++; $display("FAIL lock_bad_id_err err=%0b status=%h exp=1/0", o_err[0], o_status[0]); end
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    n_chk++; if (o_err[0] !== 1'b0 || o_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bad_id_after err=%0b valid=%0b exp=0/0", o_err[0], o_valid[0]); end
    drive_cycle(1'b1, mk(8'h09, 8'h01), 4'd2, 1'b1, 1'b0);
    n_chk++; if (o_err[0] !== 1'b1 || o_valid[0] !== 1'b0 || o_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bad_cmd err=%0b valid=%0b ready=%0b exp=1/0/1", o_err[0], o_valid[0], o_ready[0]); end
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    n_chk++; if (o_err[0] !== 1'b0) begin n_fail++; $display("FAIL bad_cmd_pulse got=%0b exp=0", o_err[0]); end
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, mk(8'h04, 8'h01), 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, mk(8'h04, 8'h03), 4'd5, 1'b0, 1'b0);
      n_chk++; if (o_data[0] !== 64'h0101 || o_dest[0] !== 4'd2) begin n_fail++; $display("FAIL stall_data cyc=%0d got=%h/%0d exp=0101/2", i, o_data[0], o_dest[0]); end
      n_chk++; if (o_ready[0] !== 1'b0 || o_valid[0] !== 1'b1) begin n_fail++; $display("FAIL stall_ctrl cyc=%0d ready=%0b valid=%0b exp=0/1", i, o_ready[0], o_valid[0]); end
    end
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    n_chk++; if (o_valid[0] !== 1'b0) begin n_fail++; $display("FAIL stall_release got=%0b exp=0", o_valid[0]); end
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    n_chk++; if (o_valid[0] !== 1'b0 || o_ready[0] !== 1'b1) begin n_fail++; $display("FAIL single_handshake valid=%0b ready=%0b exp=0/1", o_valid[0], o_ready[0]); end
    n_chk++; if (o_status[0] !== 16'h0002) begin n_fail++; $display("FAIL stall_status got=%h exp=0002", o_status[0]); end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, mk(8'h04, 8'h02), 4'd4, 1'b0, 1'b1);
    n_chk++; if (o_valid[0] !== 1'b1 || o_data[0] !== 64'h0201) begin n_fail++; $display("FAIL flush_lock_resp valid=%0b data=%h exp=1/0201", o_valid[0], o_data[0]); end
    n_chk++; if (o_status[0] !== 16'd0 || o_status[1] !== 16'd0) begin n_fail++; $display("FAIL flush_lock_status got=%h/%h exp=0", o_status[0], o_status[1]); end
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    drive_cycle(1'b1, mk(8'h04, 8'h07), 4'd4, 1'b0, 1'b0);
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b0, 1'b1);
    n_chk++; if (o_valid[0] !== 1'b1 || o_data[0] !== 64'h0701 || o_dest[0] !== 4'd4) begin n_fail++; $display("FAIL flush_in_resp valid=%0b data=%h dest=%0d exp=1/0701/4", o_valid[0], o_data[0], o_dest[0]); end
    n_chk++; if (o_status[0] !== 16'd0) begin n_fail++; $display("FAIL flush_in_resp_status got=%h exp=0", o_status[0]); end
    drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, mk(8'h04, 8'h06), 4'd1, 1'b0, 1'b0);
    n_chk++; if (o_valid[0] !== 1'b1 || o_status[0][6] !== 1'b1) begin n_fail++; $display("FAIL pre_reset valid=%0b held=%0b exp=1/1", o_valid[0], o_status[0][6]); end
    #2 rstn = 1'b0;
    #1;
    n_chk++; if (o_valid[0] !== 1'b0 || o_valid[1] !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got=%0b/%0b exp=0", o_valid[0], o_valid[1]); end
    n_chk++; if (o_ready[0] !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready got=%0b exp=0", o_ready[0]); end
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b1;
    #1;
    n_chk++; if (o_status[0] !== 16'd0 || o_status[1] !== 16'd0) begin n_fail++; $display("FAIL post_reset_status got=%h/%h exp=0", o_status[0], o_status[1]); end
    n_chk++; if (o_ready[0] !== 1'b1 || o_valid[0] !== 1'b0) begin n_fail++; $display("FAIL post_reset_ctrl ready=%0b valid=%0b exp=1/0", o_ready[0], o_valid[0]); end
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [7:0]  c;
    logic [7:0]  l;
    int r;
    for (int n = 0; n < 10000; n++) begin
      r = $urandom_range(0, 7);
      c = (r < 4) ? 8'h04 : (r < 7) ? 8'h06 : 8'($urandom);
      l = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
      d = {$urandom, 16'($urandom), l, c};
      drive_cycle($urandom_range(0, 3) != 0, d, 4'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (o_ready[k] !== !m_pend) begin n_fail++; $display("FAIL rnd_in_ready n=%0d k=%0d got=%0b exp=%0b", n, k, o_ready[k], !m_pend); end
        n_chk++; if (o_valid[k] !== m_pend) begin n_fail++; $display("FAIL rnd_out_valid n=%0d k=%0d got=%0b exp=%0b", n, k, o_valid[k], m_pend); end
        if (m_pend) begin
          n_chk++; if (o_data[k] !== m_rdata[k] || o_dest[k] !== m_rdest) begin n_fail++; $display("FAIL rnd_resp n=%0d k=%0d got=%h/%0d exp=%h/%0d", n, k, o_data[k], o_dest[k], m_rdata[k], m_rdest); end
        end
        n_chk++; if (o_err[k] !== m_err[k]) begin n_fail++; $display("FAIL rnd_err n=%0d k=%0d got=%0b exp=%0b", n, k, o_err[k], m_err[k]); end
        n_chk++; if (o_status[k] !== exp_status(k)) begin n_fail++; $display("FAIL rnd_status n=%0d k=%0d got=%h exp=%h", n, k, o_status[k], exp_status(k)); end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_lock_ok();
    test_reject_and_unlock();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
